mcu_bus_receiver: RTL and testbench
===================================

// Module: mcu_bus_receiver
// PURPOSE
//  Upstream ingress stage of msgpu. Samples the asynchronous MCU parallel bus
//  (mcu_bus_clock, mcu_bus[7:0], mcu_bus_command_data) in the system_clock domain.
//  Detects bus-clock rising edges and captures {command_data, byte} words into a FIFO.
//  Presents the FIFO to the msgpu command processor as a valid/ready stream.
// PARAMETERS
//  FIFO_DEPTH   16  entries; power of two, >= 4
//  SYNC_STAGES  2   synchronizer flops on every bus pin; >= 2
//  FILTER_LEN   3   consecutive equal samples needed to accept a bus-clock level (filter build only)
// PORTS
//  system_clock          in   1  sole clock, 201.6 MHz
//  reset_n               in   1  asynchronous, active-low reset
//  mcu_bus_clock         in   1  async MCU strobe; data valid at its rising edge
//  mcu_bus               in   8  async MCU data byte
//  mcu_bus_command_data  in   1  async; 1 = command byte, 0 = data byte
//  out_valid             out  1  FIFO head valid
//  out_ready             in   1  consumer accepts head when out_valid & out_ready
//  out_data              out  8  head byte
//  out_is_command        out  1  head command/data flag
//  fifo_level            out  $clog2(FIFO_DEPTH)+1  current occupancy
//  overflow              out  1  sticky: a byte was dropped while FIFO full
//  drop_count            out  8  saturating count of dropped bytes
//  clear_status          in   1  1-cycle pulse: clears overflow and drop_count
// BEHAVIOUR
//  - Reset: all sync flops 0, prev-clock 0, FIFO empty, out_valid 0, out_data 0,
//    out_is_command 0, fifo_level 0, overflow 0, drop_count 0. Reset mid-transfer discards FIFO contents.
//  - All 10 bus pins pass through SYNC_STAGES flops of identical depth, so the byte stays aligned with the strobe.
//  - Protocol contract: MCU holds data/flag stable >= SYNC_STAGES+1 system_clock cycles
//    before and after the mcu_bus_clock rising edge. Minimum strobe high and low time is 3 cycles.
//  - rise = synced_clk & ~prev_clk. A rise writes {synced flag, synced byte} at the next edge.
//  - Latency: first cycle the pin is sampled high -> out_valid high SYNC_STAGES+1 cycles later
//    (3 at default) when the FIFO was empty. Falling edges are ignored.
//  - Pop when out_valid & out_ready. Head data is registered (first-word fall-through).
//    out_data and out_is_command hold their value while out_valid is 0.
//  - Push and pop in the same cycle: both happen; level is unchanged.
//    Full FIFO plus pop in the same cycle: the push is accepted.
//  - Full without pop: byte dropped; overflow <= 1; drop_count increments and saturates at 255.
//  - clear_status coinciding with a drop: the clear takes effect, then the count is 1 and overflow is 1.
//  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Level uses one extra bit, so full = FIFO_DEPTH.
// CONFIGURATION
//  MCU_BUS_RX_GLITCH_FILTER_EN defined:
//   - The synced strobe feeds a FILTER_LEN-deep shift/compare.
//   - The filtered level changes only after FILTER_LEN equal samples. Shorter pulses are ignored.
//   - Latency grows by FILTER_LEN-1 cycles. Data is delayed by the same amount to stay aligned.
//  Undefined: no filter; a rise is taken directly from the synchronizer output.
// STRUCTURE
//  - Shared package msgpu_pkg: MCU_BUS_WIDTH=8, the bus-word typedef {is_command, data[7:0]},
//    and the DROP_COUNT_WIDTH=8 constant.
//  - One sub-module, mcu_bus_rx_fifo: synchronous FIFO with push/pop/full/empty/level.
//  - Synchronizer, filter, edge detect and status logic stay in the top.
// TESTING
//  1. Reset, then send cmd 0xA5 then data 0x3C, out_ready=1.
//     -> words {1,A5},{0,3C} in order; out_valid rises 3 cycles after each strobe sample.
//  2. out_ready=0; send 18 bytes 0x00..0x11 (depth 16).
//     -> level=16; overflow=1; drop_count=2; popped data is 0x00..0x0F.
//  3. FIFO full; strobe rise coincides with a pop.
//     -> push accepted; level stays 16; overflow unchanged.
//  4. With filter: a 2-cycle high glitch on mcu_bus_clock -> no push.
//     A 6-cycle pulse -> exactly one push.
//  5. Assert reset_n low while 5 entries are queued and a strobe is mid-pulse.
//     -> after release, out_valid=0, level=0; the next clean strobe is received correctly.
//  6. 300 drops, then clear_status -> drop_count saturates at 255 then reads 0; overflow clears.

Source files
------------

// File: rtl/msgpu_pkg.sv
// Shared msgpu types: MCU bus word layout and status counter width.
package msgpu_pkg;
  localparam int MCU_BUS_WIDTH    = 8;
  localparam int DROP_COUNT_WIDTH = 8;

  typedef struct packed {
    logic                     is_command;
    logic [MCU_BUS_WIDTH-1:0] data;
  } mcu_bus_word_t;

  localparam int MCU_WORD_WIDTH = $bits(mcu_bus_word_t);
endpackage

// File: rtl/mcu_bus_rx_fifo.sv
// Sync FIFO with a registered head word; a push reaches head_vld two edges later when empty.
// Push is refused only when full with no pop in the same cycle; the caller accounts the drop.
module mcu_bus_rx_fifo
  import msgpu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = MCU_WORD_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     head_vld,
  output logic [WIDTH-1:0]         head_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d, mem_cnt;
  logic             head_vld_q, head_vld_d;
  logic [WIDTH-1:0] head_dat_q, head_dat_d;
  logic             pop_ok, push_ok, load;

  // level counts the head register plus the words still in the array
  always_comb begin
    full       = (level_q == (AW+1)'(DEPTH));
    mem_cnt    = level_q - (AW+1)'(head_vld_q);
    pop_ok     = pop & head_vld_q;
    push_ok    = push & (~full | pop_ok);
    load       = (~head_vld_q | pop_ok) & (mem_cnt != '0);
    wr_ptr_d   = wr_ptr_q + AW'(push_ok);
    rd_ptr_d   = rd_ptr_q + AW'(load);
    level_d    = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    head_vld_d = head_vld_q;
    head_dat_d = head_dat_q;
    if (load) begin
      head_vld_d = 1'b1;
      head_dat_d = mem_q[rd_ptr_q];
    end else if (pop_ok) begin
      head_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      head_vld_q <= 1'b0;
      head_dat_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      head_vld_q <= head_vld_d;
      head_dat_q <= head_dat_d;
    end
  end

  assign level    = level_q;
  assign head_vld = head_vld_q;
  assign head_dat = head_dat_q;
endmodule

// File: rtl/mcu_bus_receiver.sv
// MCU parallel bus ingress: sync, strobe rise detect, FIFO; out_valid SYNC_STAGES+1 cycles after strobe
// (+FILTER_LEN-1 with MCU_BUS_RX_GLITCH_FILTER_EN); bytes arriving while full without a pop are dropped and counted.
module mcu_bus_receiver
  import msgpu_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
`ifdef MCU_BUS_RX_GLITCH_FILTER_EN
  , parameter int FILTER_LEN = 3
`endif
) (
  input  logic                          system_clock,
  input  logic                          reset_n,
  input  logic                          mcu_bus_clock,
  input  logic [MCU_BUS_WIDTH-1:0]      mcu_bus,
  input  logic                          mcu_bus_command_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MCU_BUS_WIDTH-1:0]      out_data,
  output logic                          out_is_command,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [DROP_COUNT_WIDTH-1:0]   drop_count,
  input  logic                          clear_status
);
  localparam int PIN_W = MCU_WORD_WIDTH + 1;

  // every pin rides the same chain so the byte stays aligned with the strobe
  logic [SYNC_STAGES-1:0][PIN_W-1:0] sync_q, sync_d;
  logic          sync_clk, clk_lvl, prev_clk_q, prev_clk_d, rise;
  mcu_bus_word_t sync_word, cap_word, head_word;
  logic          pop, full, drop, head_vld, overflow_q, overflow_d;
  logic [DROP_COUNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic [MCU_WORD_WIDTH-1:0]   head_dat;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], {mcu_bus_command_data, mcu_bus, mcu_bus_clock}};
    sync_clk  = sync_q[SYNC_STAGES-1][0];
    sync_word = mcu_bus_word_t'(sync_q[SYNC_STAGES-1][PIN_W-1:1]);
  end

`ifdef MCU_BUS_RX_GLITCH_FILTER_EN
  logic [FILTER_LEN-2:0] hist_q, hist_d;
  logic [FILTER_LEN-1:0] win;
  logic [FILTER_LEN-2:0][MCU_WORD_WIDTH-1:0] dly_q, dly_d;
  logic [FILTER_LEN-1:0][MCU_WORD_WIDTH-1:0] dwin;

  // level moves only on FILTER_LEN agreeing samples; data delayed to match
  always_comb begin
    win      = {hist_q, sync_clk};
    hist_d   = win[FILTER_LEN-2:0];
    clk_lvl  = (&win) ? 1'b1 : ((~|win) ? 1'b0 : prev_clk_q);
    dwin     = {dly_q, sync_word};
    dly_d    = dwin[FILTER_LEN-2:0];
    cap_word = mcu_bus_word_t'(dly_q[FILTER_LEN-2]);
  end

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= '0;
      dly_q  <= '0;
    end else begin
      hist_q <= hist_d;
      dly_q  <= dly_d;
    end
  end
`else
  always_comb begin
    clk_lvl  = sync_clk;
    cap_word = sync_word;
  end
`endif

  always_comb begin
    prev_clk_d = clk_lvl;
    rise       = clk_lvl & ~prev_clk_q;
    pop        = head_vld & out_ready;
    drop       = rise & full & ~pop;
    overflow_d = clear_status ? 1'b0 : overflow_q;
    drop_cnt_d = clear_status ? '0 : drop_cnt_q;
    // a drop in the clear cycle counts after the clear
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_d != '1) drop_cnt_d = drop_cnt_d + DROP_COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      prev_clk_q <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      sync_q     <= sync_d;
      prev_clk_q <= prev_clk_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  mcu_bus_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (MCU_WORD_WIDTH)
  ) u_fifo (
    .clk      (system_clock),
    .rst_n    (reset_n),
    .push     (rise),
    .push_dat (cap_word),
    .pop      (pop),
    .full     (full),
    .level    (fifo_level),
    .head_vld (head_vld),
    .head_dat (head_dat)
  );

  always_comb begin
    head_word      = mcu_bus_word_t'(head_dat);
    out_valid      = head_vld;
    out_data       = head_word.data;
    out_is_command = head_word.is_command;
    overflow       = overflow_q;
    drop_count     = drop_cnt_q;
  end
endmodule

// File: tb/tb_mcu_bus_receiver.sv
// Bench for mcu_bus_receiver: expected words queued at stimulus time, compared as the DUT pops them.
module tb_mcu_bus_receiver;
  import msgpu_pkg::*;

`ifdef MCU_BUS_RX_GLITCH_FILTER_EN
  localparam int LAT  = 5;
  localparam bit FILT = 1'b1;
`else
  localparam int LAT  = 3;
  localparam bit FILT = 1'b0;
`endif

  logic       clk, reset_n, mcu_bus_clock, mcu_bus_command_data;
  logic [7:0] mcu_bus, out_data, drop_count;
  logic       out_valid, out_ready, out_is_command, overflow, clear_status;
  logic [4:0] fifo_level;

  logic [8:0] exp_q[$];
  int n_chk = 0;
  int n_err = 0;

  mcu_bus_receiver dut (
    .system_clock         (clk),
    .reset_n              (reset_n),
    .mcu_bus_clock        (mcu_bus_clock),
    .mcu_bus              (mcu_bus),
    .mcu_bus_command_data (mcu_bus_command_data),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_data             (out_data),
    .out_is_command       (out_is_command),
    .fifo_level           (fifo_level),
    .overflow             (overflow),
    .drop_count           (drop_count),
    .clear_status         (clear_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every accepted pop must match the oldest expected word
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("sb_word", 32'({out_is_command, out_data}), 32'(exp_q.pop_front()));
    end
  end

  task automatic send(input logic c, input logic [7:0] b, input int hi, input bit lat);
    mcu_bus_command_data = c;
    mcu_bus = b;
    repeat (3) tick();
    mcu_bus_clock = 1'b1;
    if (lat) begin
      repeat (LAT) @(posedge clk);
      @(negedge clk);
      chk("lat_pre", 32'(out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("lat_rise", 32'(out_valid), 32'd1);
      tick();
    end else begin
      repeat (hi) tick();
    end
    mcu_bus_clock = 1'b0;
    repeat (4) tick();
  endtask

  // strobe whose FIFO write edge coincides with a pop and/or a status clear
  task automatic strobe_on_push(input logic [7:0] b, input bit do_pop, input bit do_clr);
    mcu_bus_command_data = 1'b0;
    mcu_bus = b;
    repeat (3) tick();
    mcu_bus_clock = 1'b1;
    repeat (LAT - 1) tick();
    out_ready = do_pop;
    clear_status = do_clr;
    tick();
    out_ready = 1'b0;
    clear_status = 1'b0;
    repeat (3) tick();
    mcu_bus_clock = 1'b0;
    repeat (4) tick();
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (exp_q.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    out_ready = 1'b0;
    chk("drain_done", 32'(ok), 32'd1);
    chk("drain_level", 32'(fifo_level), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    mcu_bus_clock = 1'b0;
    mcu_bus = 8'h00;
    mcu_bus_command_data = 1'b0;
    out_ready = 1'b0;
    clear_status = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_data", 32'({out_is_command, out_data}), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // in-order delivery and strobe-to-valid latency
    out_ready = 1'b1;
    exp_q.push_back(9'h1A5);
    send(1'b1, 8'hA5, 4, 1'b1);
    exp_q.push_back(9'h03C);
    send(1'b0, 8'h3C, 4, 1'b1);
    tick();
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t1_level", 32'(fifo_level), 32'd0);
    chk("t1_hold_data", 32'({out_is_command, out_data}), 32'h03C);

    // overflow: 18 bytes into a 16-deep FIFO with no consumer
    out_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) exp_q.push_back({1'b0, 8'(i)});
      send(1'b0, 8'(i), 4, 1'b0);
    end
    chk("t2_level", 32'(fifo_level), 32'd16);
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_drop", 32'(drop_count), 32'd2);

    // full FIFO with a pop on the write edge accepts the byte
    exp_q.push_back(9'h077);
    strobe_on_push(8'h77, 1'b1, 1'b0);
    chk("t3_level", 32'(fifo_level), 32'd16);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_drop", 32'(drop_count), 32'd2);
    drain();

    // short strobe pulse then a clean 6-cycle pulse
    if (!FILT) exp_q.push_back(9'h05A);
    send(1'b0, 8'h5A, 2, 1'b0);
    chk("t4_glitch_level", 32'(fifo_level), FILT ? 32'd0 : 32'd1);
    exp_q.push_back(9'h1C3);
    send(1'b1, 8'hC3, 6, 1'b0);
    chk("t4_pulse_level", 32'(fifo_level), FILT ? 32'd1 : 32'd2);
    drain();

    // reset with queued entries and a strobe mid-pulse
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({1'b1, 8'(8'h40 + i)});
      send(1'b1, 8'(8'h40 + i), 4, 1'b0);
    end
    chk("t5_pre_level", 32'(fifo_level), 32'd5);
    mcu_bus = 8'h99;
    repeat (3) tick();
    mcu_bus_clock = 1'b1;
    tick();
    reset_n = 1'b0;
    repeat (2) tick();
    mcu_bus_clock = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_q.delete();
    repeat (2) tick();
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_level", 32'(fifo_level), 32'd0);
    chk("t5_data", 32'({out_is_command, out_data}), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    exp_q.push_back(9'h142);
    send(1'b1, 8'h42, 4, 1'b1);
    drain();

    // drop counter saturation, clear colliding with a drop, plain clear
    for (int i = 0; i < 316; i++) begin
      if (i < 16) exp_q.push_back({1'b0, 8'(i + 8'h80)});
      send(1'b0, 8'(i + 8'h80), 4, 1'b0);
    end
    chk("t6_drop_sat", 32'(drop_count), 32'd255);
    chk("t6_ovf", 32'(overflow), 32'd1);
    strobe_on_push(8'hEE, 1'b0, 1'b1);
    chk("t6_clr_drop_cnt", 32'(drop_count), 32'd1);
    chk("t6_clr_drop_ovf", 32'(overflow), 32'd1);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    tick();
    chk("t6_clr_cnt", 32'(drop_count), 32'd0);
    chk("t6_clr_ovf", 32'(overflow), 32'd0);
    chk("t6_full_level", 32'(fifo_level), 32'd16);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
